// File: rtl/clock_div_ctrl.sv
// clock_div_ctrl: sequencing controller for the TRNG ring divider.
// Resets the divider, waits for it to settle, then samples raw_bit on every
// synchronised rising edge of div_clk and packs the samples into words.
//
// Output handshake: word_out/word_valid form a valid/ready source. Once
// word_valid rises, word_out is held stable and word_valid stays high until a
// cycle with word_ready high; that cycle is the transfer. word_valid drops on
// the following cycle. word_ready is ignored whenever word_valid is low.
module clock_div_ctrl #(
  parameter int SETTLE_CYCLES = 8,
  parameter int WORD_BITS     = 8,
  parameter int SYNC_STAGES   = 2,
  parameter int TIMEOUT       = 255
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 run,
  input  logic                 mode_auto,
  input  logic [1:0]           sel_cfg,
  input  logic                 div_clk,
  input  logic                 raw_bit,
  output logic [1:0]           div_sel,
  output logic                 div_rst_n,
  output logic [WORD_BITS-1:0] word_out,
  output logic                 word_valid,
  input  logic                 word_ready,
  output logic                 busy,
  output logic                 timeout_err
);

  localparam int SET_W = $clog2(SETTLE_CYCLES + 1);
  localparam int BIT_W = $clog2(WORD_BITS + 1);
  localparam int TO_W  = $clog2(TIMEOUT + 1);

  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [BIT_W-1:0] BIT_LAST    = BIT_W'(WORD_BITS - 1);
  localparam logic [TO_W-1:0]  TO_LAST     = TO_W'(TIMEOUT - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    DIV_RST = 3'd1,
    SETTLE  = 3'd2,
    COLLECT = 3'd3,
    PRESENT = 3'd4
  } state_t;

  state_t                 state_q;
  logic [SYNC_STAGES-1:0] sync_q;
  logic                   prev_q;
  logic                   rise;
  logic                   rst_cnt_q;
  logic [SET_W-1:0]       settle_cnt_q;
  logic [BIT_W-1:0]       bit_cnt_q;
  logic [TO_W-1:0]        to_cnt_q;

  // Bring div_clk into the clk domain and keep one extra stage for edge detect.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= '0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[SYNC_STAGES-2:0], div_clk};
      prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign rise = sync_q[SYNC_STAGES-1] & ~prev_q;
  assign busy = (state_q != IDLE);

  // Sequencer: divider reset, settle, collect samples, present the word.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= IDLE;
      div_sel      <= 2'd0;
      div_rst_n    <= 1'b0;
      word_out     <= '0;
      word_valid   <= 1'b0;
      timeout_err  <= 1'b0;
      rst_cnt_q    <= 1'b0;
      settle_cnt_q <= '0;
      bit_cnt_q    <= '0;
      to_cnt_q     <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          div_rst_n  <= 1'b0;
          word_valid <= 1'b0;
          if (run) begin
            div_sel     <= sel_cfg;
            timeout_err <= 1'b0;
            rst_cnt_q   <= 1'b0;
            state_q     <= DIV_RST;
          end
        end

        DIV_RST: begin
          // Two cycles with the divider held in reset.
          div_rst_n <= 1'b0;
          if (rst_cnt_q) begin
            div_rst_n    <= 1'b1;
            settle_cnt_q <= '0;
            state_q      <= SETTLE;
          end else begin
            rst_cnt_q <= 1'b1;
          end
        end

        SETTLE: begin
          // Edges seen here are ignored; the divider output is not trusted yet.
          if (settle_cnt_q == SETTLE_LAST) begin
            bit_cnt_q <= '0;
            to_cnt_q  <= '0;
            state_q   <= COLLECT;
          end else begin
            settle_cnt_q <= settle_cnt_q + 1'b1;
          end
        end

        COLLECT: begin
          // A stall is reported even when run drops in the same cycle.
          if (!rise && (to_cnt_q == TO_LAST)) begin
            timeout_err <= 1'b1;
            word_valid  <= 1'b0;
            div_rst_n   <= 1'b0;
            state_q     <= IDLE;
          end else if (!run) begin
            div_rst_n <= 1'b0;
            state_q   <= IDLE;
          end else if (rise) begin
            word_out <= {word_out[WORD_BITS-2:0], raw_bit};
            to_cnt_q <= '0;
            if (bit_cnt_q == BIT_LAST) begin
              word_valid <= 1'b1;
              state_q    <= PRESENT;
            end else begin
              bit_cnt_q <= bit_cnt_q + 1'b1;
            end
          end else begin
            to_cnt_q <= to_cnt_q + 1'b1;
          end
        end

        PRESENT: begin
          // The word is always delivered, even if run has already dropped.
          if (word_ready) begin
            word_valid <= 1'b0;
            if (!run) begin
              div_rst_n <= 1'b0;
              state_q   <= IDLE;
            end else if (mode_auto) begin
              div_sel   <= div_sel + 2'd1;
              div_rst_n <= 1'b0;
              rst_cnt_q <= 1'b0;
              state_q   <= DIV_RST;
            end else begin
              bit_cnt_q <= '0;
              to_cnt_q  <= '0;
              state_q   <= COLLECT;
            end
          end
        end

        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_clock_div_ctrl.sv
// tb_clock_div_ctrl: directed sequence with randomised sample bits and
// consumer delays, checked against a sample-level model of the controller.
module tb_clock_div_ctrl;

  localparam int SETTLE_CYCLES = 8;
  localparam int WORD_BITS     = 8;
  localparam int SYNC_STAGES   = 2;
  localparam int TIMEOUT       = 255;

  // ---------------- clock / reset ----------------
  logic                 clk = 1'b0;
  logic                 rst = 1'b1;
  logic                 run = 1'b0;
  logic                 mode_auto = 1'b0;
  logic [1:0]           sel_cfg = 2'd0;
  logic                 div_clk = 1'b0;
  logic                 raw_bit = 1'b0;
  logic [1:0]           div_sel;
  logic                 div_rst_n;
  logic [WORD_BITS-1:0] word_out;
  logic                 word_valid;
  logic                 word_ready = 1'b0;
  logic                 busy;
  logic                 timeout_err;

  always #5 clk = ~clk;

  clock_div_ctrl #(
    .SETTLE_CYCLES (SETTLE_CYCLES),
    .WORD_BITS     (WORD_BITS),
    .SYNC_STAGES   (SYNC_STAGES),
    .TIMEOUT       (TIMEOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .run         (run),
    .mode_auto   (mode_auto),
    .sel_cfg     (sel_cfg),
    .div_clk     (div_clk),
    .raw_bit     (raw_bit),
    .div_sel     (div_sel),
    .div_rst_n   (div_rst_n),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .busy        (busy),
    .timeout_err (timeout_err)
  );

  // ---------------- scoreboard ----------------
  logic [WORD_BITS-1:0] exp_q[$];
  int errors = 0;
  int checks = 0;
  int acc    = 0;   // model: running value of the word being sampled
  int rst_low_total = 0;

  // Counts cycles in which the divider is held in reset while the controller is active.
  always @(negedge clk) begin
    if (busy === 1'b1 && div_rst_n === 1'b0) rst_low_total <= rst_low_total + 1;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(negedge clk);
  endtask

  // One div_clk period per bit; raw_bit only changes while div_clk is low.
  task automatic send_bits(input int n, input logic [31:0] pat, input bit use_rand);
    bit b;
    for (int i = 0; i < n; i++) begin
      b = use_rand ? 1'($urandom_range(0, 1)) : pat[n-1-i];
      acc = acc * 2 + int'(b);
      raw_bit = b;
      div_clk = 1'b1;
      repeat (5) tick();
      div_clk = 1'b0;
      repeat (5) tick();
    end
  endtask

  // Counts divider-reset cycles from the current sample until div_rst_n rises.
  task automatic measure_reset(input string tag, input logic [1:0] exp_sel);
    int cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (div_rst_n === 1'b1) break;
      if (busy === 1'b1) cnt++;
      tick();
    end
    check({tag, "_rst_cycles"}, 32'(cnt), 32'd2);
    check({tag, "_div_sel"}, 32'(div_sel), 32'(exp_sel));
    repeat (SETTLE_CYCLES + 2) tick();
  endtask

  task automatic start_run(input string tag, input logic [1:0] sel, input logic auto_m);
    sel_cfg = sel;
    mode_auto = auto_m;
    run = 1'b1;
    tick();
    measure_reset(tag, sel);
  endtask

  task automatic collect_word(input string tag, input logic [31:0] pat, input bit use_rand,
                              input logic [1:0] exp_sel);
    acc = 0;
    send_bits(WORD_BITS, pat, use_rand);
    exp_q.push_back(WORD_BITS'(acc));
    for (int i = 0; i < 10 && word_valid !== 1'b1; i++) tick();
    check({tag, "_valid"}, 32'(word_valid), 32'd1);
    check({tag, "_word"}, 32'(word_out), 32'(exp_q.pop_front()));
    check({tag, "_sel"}, 32'(div_sel), 32'(exp_sel));
  endtask

  task automatic transfer(input string tag);
    word_ready = 1'b1;
    tick();
    word_ready = 1'b0;
    check({tag, "_valid_drop"}, 32'(word_valid), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int  base;
    int  elapsed;
    bit  ok;
    logic [WORD_BITS-1:0] held;

    // Reset with run already high: reset must dominate.
    run = 1'b1;
    repeat (3) tick();
    check("rst_div_sel", 32'(div_sel), 32'd0);
    check("rst_div_rst_n", 32'(div_rst_n), 32'd0);
    check("rst_word_out", 32'(word_out), 32'd0);
    check("rst_word_valid", 32'(word_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_timeout_err", 32'(timeout_err), 32'd0);
    run = 1'b0;
    rst = 1'b0;
    tick();
    check("idle_busy", 32'(busy), 32'd0);

    // Fixed mode, tap 2, known pattern 1,0,1,1,0,0,1,0.
    start_run("fixed", 2'd2, 1'b0);
    collect_word("fixed_w0", 32'hB2, 1'b0, 2'd2);
    check("fixed_w0_const", 32'(word_out), 32'hB2);

    // Consumer stalls; div_clk keeps toggling but nothing new is sampled.
    held = word_out;
    ok = 1'b1;
    send_bits(1, 32'h0, 1'b1);
    for (int i = 0; i < 10; i++) begin
      if (word_out !== held || word_valid !== 1'b1) ok = 1'b0;
      tick();
    end
    check("hold_stable", 32'(ok), 32'd1);
    check("hold_word", 32'(word_out), 32'hB2);
    transfer("fixed_w0");

    // Next word in fixed mode: same tap, no divider reset.
    base = rst_low_total;
    collect_word("fixed_w1", 32'h0, 1'b1, 2'd2);
    check("fixed_no_rerst", 32'(rst_low_total - base), 32'd0);
    repeat ($urandom_range(0, 4)) tick();
    transfer("fixed_w1");

    // Drop run after three samples: partial word discarded.
    send_bits(3, 32'h0, 1'b1);
    run = 1'b0;
    tick();
    check("drop_busy", 32'(busy), 32'd0);
    check("drop_div_rst_n", 32'(div_rst_n), 32'd0);
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      if (word_valid !== 1'b0 || busy !== 1'b0) ok = 1'b0;
      tick();
    end
    check("drop_quiet", 32'(ok), 32'd1);

    // Auto mode from tap 3: taps visit 3,0,1,2,3 with a reset before each.
    start_run("auto", 2'd3, 1'b1);
    for (int k = 0; k < 5; k++) begin
      collect_word("auto_w", 32'h0, 1'b1, 2'((3 + k) % 4));
      repeat ($urandom_range(0, 5)) tick();
      if (k < 4) begin
        transfer("auto_w");
        measure_reset("auto_step", 2'((4 + k) % 4));
      end
    end
    // Word still delivered when run drops with the transfer; then idle.
    run = 1'b0;
    transfer("auto_last");
    check("auto_last_idle", 32'(busy), 32'd0);

    // Stall div_clk mid-word: timeout after TIMEOUT edge-free cycles.
    start_run("to", 2'd1, 1'b0);
    send_bits(3, 32'h0, 1'b1);
    elapsed = 10;
    for (int i = 0; i < TIMEOUT + 100; i++) begin
      tick();
      elapsed++;
      if (busy !== 1'b1) break;
    end
    check("to_busy", 32'(busy), 32'd0);
    check("to_err", 32'(timeout_err), 32'd1);
    check("to_valid", 32'(word_valid), 32'd0);
    check("to_not_early", 32'(elapsed > TIMEOUT), 32'd1);
    check("to_not_late", 32'(elapsed <= TIMEOUT + SYNC_STAGES + 5), 32'd1);
    tick();
    check("to_restart_busy", 32'(busy), 32'd1);
    check("to_restart_clear", 32'(timeout_err), 32'd0);
    run = 1'b0;
    for (int i = 0; i < 40 && busy !== 1'b0; i++) tick();
    check("to_back_idle", 32'(busy), 32'd0);

    // Reset while a word is being presented.
    start_run("rp", 2'd0, 1'b0);
    collect_word("rp_w", 32'h0, 1'b1, 2'd0);
    run = 1'b0;
    rst = 1'b1;
    tick();
    check("rp_valid", 32'(word_valid), 32'd0);
    check("rp_word", 32'(word_out), 32'd0);
    check("rp_busy", 32'(busy), 32'd0);
    check("rp_div_rst_n", 32'(div_rst_n), 32'd0);
    rst = 1'b0;
    tick();
    check("exp_q_drained", 32'(exp_q.size()), 32'd0);

    // ---------------- final report ----------------
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  // Safety net so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

endmodule
